iter_divider: RTL

Parametrised iterative radix-2 integer divider for the execute stage. It computes quotient and remainder for signed or unsigned operands, at full width or in half-width "word" mode. It returns results over a valid/ready handshake and takes one iteration per quotient bit. Divide-by-zero and signed overflow are resolved in a single cycle without iterating. A flush input kills an in-flight operation.

---
 rtl/iter_divider.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider: signed/unsigned, full width or half-width word mode.
// Latency: N+1 cycles from accept to out_valid (N = WIDTH or WIDTH/2); 1 cycle for divide-by-zero/overflow.
// Backpressure: single operation in flight; result held in DONE until out_ready, in_ready only in IDLE.
module iter_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic             word,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int HW = WIDTH / 2;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             sign_q, sign_d;
  logic             word_q, word_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  // Operand conditioning at accept time
  logic [WIDTH-1:0] mask, x_n, y_n, x_abs, y_abs, x_min;
  logic             x_msb, y_msb, y_zero, ovf, accept;

  // Restoring step datapath
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] q_fix, r_fix;

  function automatic logic [WIDTH-1:0] sext_hw(input logic [HW-1:0] v);
    return {{HW{v[HW-1]}}, v};
  endfunction

  assign in_ready  = rst && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

  // Truncate operands to N bits, take magnitudes, and detect the single-cycle special cases
  always_comb begin
    mask   = word ? {{HW{1'b0}}, {HW{1'b1}}} : {WIDTH{1'b1}};
    x_n    = x & mask;
    y_n    = y & mask;
    x_msb  = word ? x[HW-1] : x[WIDTH-1];
    y_msb  = word ? y[HW-1] : y[WIDTH-1];
    x_abs  = (sign && x_msb) ? ((~x_n + WIDTH'(1)) & mask) : x_n;
    y_abs  = (sign && y_msb) ? ((~y_n + WIDTH'(1)) & mask) : y_n;
    x_min  = mask ^ (mask >> 1);
    y_zero = (y_n == '0);
    ovf    = sign && (x_n == x_min) && (y_n == mask);
    accept = in_valid && in_ready && !flush;
  end

  // Next-state, iteration and result-fixup logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    sign_d      = sign_q;
    word_d      = word_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value.
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, div_q};

    q_fix = (sign_q && neg_quo_q) ? -quo_q : quo_q;
    r_fix = (sign_q && neg_rem_q) ? -rem_q : rem_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d = sign;
          word_d = word;
          if (y_zero || ovf) begin
            // Raw results pass through FIX for sign extension only, so clear the negate flags.
            state_d   = FIX;
            cnt_d     = '0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            quo_d     = y_zero ? {WIDTH{1'b1}} : x_n;
            rem_d     = y_zero ? x_n : '0;
            div_d     = '0;
          end else begin
            state_d   = CALC;
            cnt_d     = word ? CW'(HW) : CW'(WIDTH);
            neg_quo_d = x_msb ^ y_msb;
            neg_rem_d = x_msb;
            // Word mode parks the dividend in the upper half so its MSB shifts out first.
            quo_d     = word ? (x_abs << HW) : x_abs;
            rem_d     = '0;
            div_d     = y_abs;
          end
        end
      end
      CALC: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // Word results are sign-extended even for unsigned ops (divuw/remuw behaviour).
        quotient_d  = word_q ? sext_hw(q_fix[HW-1:0]) : q_fix;
        remainder_d = word_q ? sext_hw(r_fix[HW-1:0]) : r_fix;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      sign_q      <= 1'b0;
      word_q      <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      sign_q      <= sign_d;
      word_q      <= word_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

endmodule
